tt_extractor: RTL and testbench
===============================

TT_EXTRACTOR -- requirements
Module: tt_extractor

Interface
REQ-001 SHALL have parameter: SETTLE_CYCLES, default 2, number of extra cycles each input vector is held before sampling (legal range 0..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to characterise the attached 4-input gate.
REQ-005 SHALL have port: dut_in  output  4  vector driven to the gate under test; bit k drives gate input _k.
REQ-006 SHALL have port: dut_out  input  1  single output of the gate under test.
REQ-007 SHALL have port: busy  output  1  high while a sweep is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when a sweep completes.
REQ-009 SHALL have port: tt  output  16  extracted truth table; bit i = dut_out sampled while dut_in == i.

Function
REQ-010 SHALL implement states IDLE, SETTLE and DONE.
REQ-011 In IDLE, start=1 SHALL be accepted; on the next edge: idx=0, dut_in=0, settle counter=SETTLE_CYCLES, tt=0, busy=1, state=SETTLE.
REQ-012 In SETTLE with counter>0, the counter SHALL decrement, with dut_in and idx held.
REQ-013 In SETTLE with counter==0: tt[idx] SHALL load dut_out; if idx<15, then idx and dut_in SHALL increment and the counter SHALL reload to SETTLE_CYCLES; if idx==15, state SHALL go to DONE.
REQ-014 Each vector SHALL be driven for exactly SETTLE_CYCLES+1 cycles and sampled in its last cycle.
REQ-015 A sweep SHALL take 16*(SETTLE_CYCLES+1) cycles in SETTLE.
REQ-016 In DONE: done=1 and busy=0 for exactly one cycle; dut_in=0; next state IDLE.
REQ-017 start SHALL be ignored in SETTLE and DONE and SHALL NOT be queued.
REQ-018 tt SHALL hold its value from DONE until the next accepted start clears it.
REQ-019 dut_in SHALL be 0 in IDLE and DONE.
REQ-020 idx SHALL be 4 bits and SHALL NOT wrap past 15 within a sweep.

Reset
REQ-021 On rst=1 at a clock edge: state=IDLE, dut_in=0, busy=0, done=0, tt=0, counter=0, idx=0.
REQ-022 rst SHALL override start when both are asserted in the same cycle.
REQ-023 rst during SETTLE or DONE SHALL abort the sweep, and no done pulse SHALL follow.

Configuration
REQ-024 With macro TT_COMPARE_EN defined, the block SHALL add input expected[15:0] and output match (1 bit).
REQ-025 With TT_COMPARE_EN defined, match SHALL equal (tt==expected) registered in the DONE cycle, SHALL hold until the next accepted start or rst, and SHALL reset to 0.
REQ-026 Without TT_COMPARE_EN, the expected and match ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Gate model with table 0x10C9, SETTLE_CYCLES=2, start pulse -> busy for 48 cycles; done pulses once in the following cycle; tt=16'h10C9.
REQ-028 dut_out tied 1, SETTLE_CYCLES=0 -> 16 SETTLE cycles; dut_in steps 0..15, one value per cycle; tt=16'hFFFF; dut_in=0 after done.
REQ-029 start held high for the whole sweep -> exactly one sweep and one done pulse, then a second sweep starts from IDLE; tt is cleared to 0 at the second acceptance.
REQ-030 rst asserted while dut_in==7 -> next cycle all outputs 0 and state IDLE; no done pulse; a new start gives a full, correct sweep.
REQ-031 TT_COMPARE_EN defined, expected=16'h10C9, gate 0x10C9 -> match=1; expected=16'h10C8 -> match=0.
REQ-032 Gate model with table 16'hA5A5, SETTLE_CYCLES=5 -> done 96 cycles after acceptance; tt=16'hA5A5.

Source files
------------

// File: rtl/tt_extractor.sv
// tt_extractor: sweeps all 16 input vectors of an attached 4-input gate,
// holds each vector for SETTLE_CYCLES+1 cycles, samples the gate output in
// the last cycle of each vector and assembles the 16-bit truth table.
// Optional feature (macro TT_COMPARE_EN): adds an `expected` input and a
// registered `match` flag comparing the extracted table against it.
module tt_extractor #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [3:0]  dut_in,
   input  logic        dut_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] tt
`ifdef TT_COMPARE_EN
   ,
   input  logic [15:0] expected,
   output logic        match
`endif
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES);

   logic [1:0]  state_q,  state_d;
   logic [3:0]  idx_q,    idx_d;
   logic [3:0]  dut_in_q, dut_in_d;
   logic [7:0]  cnt_q,    cnt_d;
   logic [15:0] tt_q,     tt_d;
   logic        busy_q,   busy_d;
   logic        done_q,   done_d;
`ifdef TT_COMPARE_EN
   logic        match_q,  match_d;
`endif

   // Next-state logic: accept a request, step through vectors, finish sweep.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      dut_in_d = dut_in_q;
      cnt_d    = cnt_q;
      tt_d     = tt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef TT_COMPARE_EN
      match_d  = match_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_SETTLE;
               idx_d    = 4'd0;
               dut_in_d = 4'd0;
               cnt_d    = SETTLE_RELOAD;
               tt_d     = 16'h0000;
               busy_d   = 1'b1;
`ifdef TT_COMPARE_EN
               match_d  = 1'b0;
`endif
            end
         end
         ST_SETTLE: begin
            if (cnt_q != 8'd0) begin
               // Gate output still settling: hold the vector.
               cnt_d = cnt_q - 8'd1;
            end else begin
               // Last cycle of this vector: capture the gate response.
               tt_d[idx_q] = dut_out;
               if (idx_q != 4'd15) begin
                  idx_d    = idx_q + 4'd1;
                  dut_in_d = dut_in_q + 4'd1;
                  cnt_d    = SETTLE_RELOAD;
               end else begin
                  // Final vector captured; the DONE cycle shows the pulse.
                  state_d  = ST_DONE;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  dut_in_d = 4'd0;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
`ifdef TT_COMPARE_EN
            // tt is final here, so the comparison is taken now and held.
            match_d = (tt_q == expected);
`endif
         end
         default: begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            dut_in_d = 4'd0;
         end
      endcase
   end

   // State registers with synchronous reset that also aborts a running sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= 4'd0;
         dut_in_q <= 4'd0;
         cnt_q    <= 8'd0;
         tt_q     <= 16'h0000;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef TT_COMPARE_EN
         match_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         dut_in_q <= dut_in_d;
         cnt_q    <= cnt_d;
         tt_q     <= tt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef TT_COMPARE_EN
         match_q  <= match_d;
`endif
      end
   end

   assign dut_in = dut_in_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign tt     = tt_q;
`ifdef TT_COMPARE_EN
   assign match  = match_q;
`endif

endmodule

// File: tb/tb_tt_extractor.sv
// Testbench for tt_extractor: three instances with different settle times,
// each driving a behavioural gate model (lookup into a 16-bit table).
// Expected tables go into a scoreboard when a sweep is started and are
// compared when the matching done pulse appears.
module tb_tt_extractor;

   localparam int NI = 3;
   localparam int SV [NI] = '{2, 0, 5};

   logic                  clk;
   logic [NI-1:0]         rst_v;
   logic [NI-1:0]         start_v;
   logic [NI-1:0][3:0]    din_v;
   logic [NI-1:0]         dout_v;
   logic [NI-1:0]         busy_v;
   logic [NI-1:0]         done_v;
   logic [NI-1:0][15:0]   tt_v;
   logic [NI-1:0][15:0]   gate_v;
`ifdef TT_COMPARE_EN
   logic [NI-1:0][15:0]   exp_v;
   logic [NI-1:0]         match_v;
`endif

   int checks = 0;
   int errors = 0;
   int done_cnt [NI];

   typedef struct {
      int          inst;
      logic [15:0] tt;
   } sb_t;
   sb_t sb [$];

   typedef struct {
      int          inst;
      logic [15:0] gate;
      logic [15:0] expv;
   } vec_t;
   vec_t vecs [6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_dut
         tt_extractor #(.SETTLE_CYCLES(SV[gi])) u_dut (
            .clk     (clk),
            .rst     (rst_v[gi]),
            .start   (start_v[gi]),
            .dut_in  (din_v[gi]),
            .dut_out (dout_v[gi]),
            .busy    (busy_v[gi]),
            .done    (done_v[gi]),
            .tt      (tt_v[gi])
`ifdef TT_COMPARE_EN
            ,
            .expected(exp_v[gi]),
            .match   (match_v[gi])
`endif
         );
         assign dout_v[gi] = gate_v[gi][din_v[gi]];
      end
   endgenerate

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every done pulse must pair with a queued expectation.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (done_v[k] === 1'b1) begin
            sb_t e;
            done_cnt[k]++;
            if (sb.size() == 0) begin
               check("sb_unexpected_done", 32'(k), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("sb_inst", 32'(k), 32'(e.inst));
               check("sb_tt", {16'h0, tt_v[k]}, {16'h0, e.tt});
               $display("sweep inst %0d settle %0d tt %04h expected %04h",
                        k, SV[k], tt_v[k], e.tt);
            end
         end
      end
   end

   // One complete sweep on instance k with full protocol checking.
   task automatic run_sweep(input int k, input logic [15:0] gate, input logic [15:0] expv);
      int n;
      int bad;
      sb_t e;
      gate_v[k] = gate;
`ifdef TT_COMPARE_EN
      exp_v[k] = expv;
`endif
      e.inst = k;
      e.tt   = gate;
      sb.push_back(e);
      start_v[k] = 1'b1;
      tick();
      start_v[k] = 1'b0;
      check("accept_busy", 32'(busy_v[k]), 32'd1);
      check("accept_tt_clear", {16'h0, tt_v[k]}, 32'h0);
      n   = 0;
      bad = 0;
      while (busy_v[k] === 1'b1 && n < 3000) begin
         if (din_v[k] !== 4'(n / (SV[k] + 1))) bad++;
         if (done_v[k] !== 1'b0) bad++;
         n++;
         tick();
      end
      check("busy_len", 32'(n), 32'(16 * (SV[k] + 1)));
      check("din_seq", 32'(bad), 32'd0);
      check("done_pulse", 32'(done_v[k]), 32'd1);
      check("din_at_done", 32'(din_v[k]), 32'd0);
      tick();
      check("done_one_cycle", 32'(done_v[k]), 32'd0);
      check("idle_busy", 32'(busy_v[k]), 32'd0);
      check("tt_hold", {16'h0, tt_v[k]}, {16'h0, gate});
`ifdef TT_COMPARE_EN
      check("match", 32'(match_v[k]), 32'(gate == expv));
`endif
   endtask

   initial begin
      int n;
      int dc;
      for (int k = 0; k < NI; k++) done_cnt[k] = 0;
      rst_v   = '1;
      start_v = '0;
      gate_v  = '0;
`ifdef TT_COMPARE_EN
      exp_v   = '0;
`endif
      vecs[0] = '{0, 16'h10C9, 16'h10C9};
      vecs[1] = '{1, 16'hFFFF, 16'hFFFF};
      vecs[2] = '{2, 16'hA5A5, 16'hA5A5};
      vecs[3] = '{0, 16'h10C9, 16'h10C8};
      vecs[4] = '{1, 16'h8001, 16'h8001};
      vecs[5] = '{0, 16'h0000, 16'h0001};

      tick();
      tick();
      for (int k = 0; k < NI; k++) begin
         check("rst_busy", 32'(busy_v[k]), 32'd0);
         check("rst_done", 32'(done_v[k]), 32'd0);
         check("rst_din", 32'(din_v[k]), 32'd0);
         check("rst_tt", {16'h0, tt_v[k]}, 32'h0);
`ifdef TT_COMPARE_EN
         check("rst_match", 32'(match_v[k]), 32'd0);
`endif
      end
      rst_v = '0;
      tick();

      // Table-driven sweeps.
      for (int i = 0; i < 6; i++) begin
         run_sweep(vecs[i].inst, vecs[i].gate, vecs[i].expv);
      end

      // start held high through a whole sweep: one done, then a fresh sweep.
      gate_v[0] = 16'h3C5A;
      sb.push_back('{0, 16'h3C5A});
      sb.push_back('{0, 16'h3C5A});
      dc = done_cnt[0];
      start_v[0] = 1'b1;
      n = 0;
      tick();
      while (done_v[0] !== 1'b1 && n < 200) begin
         n++;
         tick();
      end
      check("hold_first_done", 32'(done_v[0]), 32'd1);
      tick();
      check("hold_idle_busy", 32'(busy_v[0]), 32'd0);
      check("hold_idle_tt", {16'h0, tt_v[0]}, 32'h3C5A);
      tick();
      check("hold_reaccept_busy", 32'(busy_v[0]), 32'd1);
      check("hold_reaccept_tt", {16'h0, tt_v[0]}, 32'h0);
      start_v[0] = 1'b0;
      n = 0;
      while (done_v[0] !== 1'b1 && n < 200) begin
         n++;
         tick();
      end
      tick();
      check("hold_done_count", 32'(done_cnt[0] - dc), 32'd2);
      check("hold_tt", {16'h0, tt_v[0]}, 32'h3C5A);

      // Reset in the middle of a sweep aborts it without a done pulse.
      gate_v[0] = 16'hFFFF;
      dc = done_cnt[0];
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      n = 0;
      while (din_v[0] !== 4'd7 && n < 200) begin
         n++;
         tick();
      end
      check("abort_reached7", 32'(din_v[0]), 32'd7);
      rst_v[0] = 1'b1;
      tick();
      rst_v[0] = 1'b0;
      check("abort_busy", 32'(busy_v[0]), 32'd0);
      check("abort_done", 32'(done_v[0]), 32'd0);
      check("abort_din", 32'(din_v[0]), 32'd0);
      check("abort_tt", {16'h0, tt_v[0]}, 32'h0);
      for (int c = 0; c < 60; c++) tick();
      check("abort_no_done", 32'(done_cnt[0] - dc), 32'd0);
      check("abort_idle", 32'(busy_v[0]), 32'd0);
      run_sweep(0, 16'h10C9, 16'h10C9);

      // Reset wins over a simultaneous start.
      rst_v[2]   = 1'b1;
      start_v[2] = 1'b1;
      tick();
      rst_v[2]   = 1'b0;
      start_v[2] = 1'b0;
      check("rst_over_start", 32'(busy_v[2]), 32'd0);
      tick();
      check("rst_over_start_idle", 32'(busy_v[2]), 32'd0);

      tick();
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
